control_fsm: RTL and testbench



---
 rtl/control_fsm.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// ---------------------------------------------------------------------------
// control_fsm -- multi-cycle main control unit for the RV32I core.
//
// Sequences every instruction through fetch, decode, execute, memory and
// writeback. The datapath enables and mux selects are decoded from the
// current state. alu_op/is_imm feed the downstream ALU decoder.
//
// Build option:
//   CTRL_TRAP_EN  When defined, an unrecognised opcode parks the FSM in TRAP
//                 with illegal_instr=1 until reset. When undefined, an
//                 unrecognised opcode is treated as a NOP (back to FETCH),
//                 illegal_instr is tied low and TRAP is unreachable.
//
// Ports:
//   clk           in   system clock, all state on rising edge
//   reset         in   synchronous, active-high
//   opcode        in   [6:0] instruction register opcode field
//   mem_ready     in   memory completes the current request this cycle
//   mem_req       out  memory access request
//   mem_write     out  request is a store
//   adr_src       out  memory address select: 0=PC, 1=ALUOut
//   ir_write      out  load instruction register
//   pc_write      out  load PC from result bus
//   branch        out  conditional PC load (gated by ALU flag in datapath)
//   reg_write     out  register file write
//   alu_src_a     out  [1:0] 00=PC, 01=oldPC, 10=rs1, 11=zero
//   alu_src_b     out  [1:0] 00=rs2, 01=imm, 10=const 4
//   result_src    out  [1:0] 00=ALUOut, 01=mem data, 10=ALU result
//   alu_op        out  [1:0] 00=add, 01=branch compare, 10=funct-decoded
//   is_imm        out  OP-IMM instruction (funct7[5] must not select SUB)
//   state         out  [3:0] current state, debug
//   illegal_instr out  FSM parked in TRAP (CTRL_TRAP_EN only)
// ---------------------------------------------------------------------------
module control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [1:0] alu_op,
   output logic       is_imm,
   output logic [3:0] state,
   output logic       illegal_instr
);

   // State encoding (also visible on the debug port)
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_EXEC_I   = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_LUI      = 4'd12;
   localparam logic [3:0] S_TRAP     = 4'd13;

   // RV32I major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Where an unrecognised opcode goes, and what TRAP does next.
`ifdef CTRL_TRAP_EN
   localparam logic [3:0] ILLEGAL_TARGET = S_TRAP;
   localparam logic [3:0] TRAP_NEXT      = S_TRAP;
`else
   localparam logic [3:0] ILLEGAL_TARGET = S_FETCH;
   localparam logic [3:0] TRAP_NEXT      = S_FETCH;
`endif

   logic [3:0] r_state;
   logic [3:0] w_state_next;

   logic       w_mem_req;
   logic       w_mem_write;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_branch;
   logic       w_reg_write;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_result_src;
   logic [1:0] w_alu_op;
   logic       w_is_imm;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = S_FETCH;
      case (r_state)
         S_FETCH: begin
            w_state_next = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD,
               OP_STORE:  w_state_next = S_MEMADR;
               OP_R:      w_state_next = S_EXEC_R;
               OP_IMM:    w_state_next = S_EXEC_I;
               OP_BRANCH: w_state_next = S_BRANCH;
               OP_JAL:    w_state_next = S_JAL;
               OP_JALR:   w_state_next = S_JALR;
               OP_LUI:    w_state_next = S_LUI;
               // AUIPC target was already formed in ALUOut during DECODE
               OP_AUIPC:  w_state_next = S_ALUWB;
               default:   w_state_next = ILLEGAL_TARGET;
            endcase
         end
         S_MEMADR: begin
            w_state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_state_next = mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            w_state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            w_state_next = mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXEC_R,
         S_EXEC_I: begin
            w_state_next = S_ALUWB;
         end
         S_ALUWB: begin
            w_state_next = S_FETCH;
         end
         S_BRANCH: begin
            w_state_next = S_FETCH;
         end
         S_JAL: begin
            w_state_next = S_ALUWB;
         end
         // JALR computes its target, then reuses the JAL link/jump step
         S_JALR: begin
            w_state_next = S_JAL;
         end
         S_LUI: begin
            w_state_next = S_ALUWB;
         end
         S_TRAP: begin
            w_state_next = TRAP_NEXT;
         end
         default: begin
            // Unused encodings recover to FETCH
            w_state_next = S_FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode. Everything defaults to 0; reset forces all outputs
   // low so an in-flight memory request is dropped immediately.
   // ------------------------------------------------------------------
   always_comb begin
      w_mem_req    = 1'b0;
      w_mem_write  = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_branch     = 1'b0;
      w_reg_write  = 1'b0;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_result_src = 2'b00;
      w_alu_op     = 2'b00;
      w_is_imm     = 1'b0;
      if (!reset) begin
         case (r_state)
            S_FETCH: begin
               w_mem_req    = 1'b1;
               w_adr_src    = 1'b0;
               w_alu_src_a  = 2'b00;
               w_alu_src_b  = 2'b10;
               w_alu_op     = 2'b00;
               w_result_src = 2'b10;
               // IR and PC+4 are captured only on the cycle the fetch completes
               w_ir_write   = mem_ready;
               w_pc_write   = mem_ready;
            end
            S_DECODE: begin
               // oldPC + imm precomputed into ALUOut for branch/JAL/AUIPC
               w_alu_src_a  = 2'b01;
               w_alu_src_b  = 2'b01;
               w_alu_op     = 2'b00;
            end
            S_MEMADR: begin
               w_alu_src_a  = 2'b10;
               w_alu_src_b  = 2'b01;
               w_alu_op     = 2'b00;
            end
            S_MEMREAD: begin
               w_mem_req    = 1'b1;
               w_adr_src    = 1'b1;
            end
            S_MEMWB: begin
               w_result_src = 2'b01;
               w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               w_mem_req    = 1'b1;
               w_mem_write  = 1'b1;
               w_adr_src    = 1'b1;
            end
            S_EXEC_R: begin
               w_alu_src_a  = 2'b10;
               w_alu_src_b  = 2'b00;
               w_alu_op     = 2'b10;
               w_is_imm     = 1'b0;
            end
            S_EXEC_I: begin
               w_alu_src_a  = 2'b10;
               w_alu_src_b  = 2'b01;
               w_alu_op     = 2'b10;
               w_is_imm     = 1'b1;
            end
            S_ALUWB: begin
               w_result_src = 2'b00;
               w_reg_write  = 1'b1;
            end
            S_BRANCH: begin
               w_alu_src_a  = 2'b10;
               w_alu_src_b  = 2'b00;
               w_alu_op     = 2'b01;
               w_result_src = 2'b00;
               w_branch     = 1'b1;
            end
            S_JAL: begin
               // Jump target comes from ALUOut while the ALU forms oldPC+4
               // as the link value, written back in ALUWB.
               w_pc_write   = 1'b1;
               w_result_src = 2'b00;
               w_alu_src_a  = 2'b01;
               w_alu_src_b  = 2'b10;
               w_alu_op     = 2'b00;
            end
            S_JALR: begin
               w_alu_src_a  = 2'b10;
               w_alu_src_b  = 2'b01;
               w_alu_op     = 2'b00;
            end
            S_LUI: begin
               // zero + imm
               w_alu_src_a  = 2'b11;
               w_alu_src_b  = 2'b01;
               w_alu_op     = 2'b00;
            end
            default: begin
               // TRAP and unused encodings drive nothing
            end
         endcase
      end
   end

   assign mem_req    = w_mem_req;
   assign mem_write  = w_mem_write;
   assign adr_src    = w_adr_src;
   assign ir_write   = w_ir_write;
   assign pc_write   = w_pc_write;
   assign branch     = w_branch;
   assign reg_write  = w_reg_write;
   assign alu_src_a  = w_alu_src_a;
   assign alu_src_b  = w_alu_src_b;
   assign result_src = w_result_src;
   assign alu_op     = w_alu_op;
   assign is_imm     = w_is_imm;

   // Debug view reads 0 while reset is held, even before the first edge
   assign state = reset ? S_FETCH : r_state;

`ifdef CTRL_TRAP_EN
   assign illegal_instr = !reset && (r_state == S_TRAP);
`else
   assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_control_fsm -- directed testbench for control_fsm.
// Each scenario task drives inputs 1 time unit after a rising edge and
// samples outputs 1 time unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_write;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       branch;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_op;
   logic       is_imm;
   logic [3:0] state;
   logic       illegal_instr;

   int total = 0;
   int bad   = 0;

   control_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .adr_src       (adr_src),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .branch        (branch),
      .reg_write     (reg_write),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .result_src    (result_src),
      .alu_op        (alu_op),
      .is_imm        (is_imm),
      .state         (state),
      .illegal_instr (illegal_instr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset held 3 cycles with mem_ready high, then release
   task automatic test_reset();
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = 7'b0000000;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (state !== 4'd0) begin
            bad++;
            $display("FAIL reset_state cyc%0d: got %0d expected 0", i, state);
         end
         total++;
         if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem_req cyc%0d: got %b expected 0", i, mem_req);
         end
         total++;
         if ({pc_write, ir_write, reg_write} !== 3'b000) begin
            bad++;
            $display("FAIL reset_enables cyc%0d: got %b expected 000", i, {pc_write, ir_write, reg_write});
         end
         tick();
      end
      reset = 1'b0;
      #1;
      total++;
      if ({mem_req, pc_write, ir_write} !== 3'b111) begin
         bad++;
         $display("FAIL post_reset_fetch: got %b expected 111", {mem_req, pc_write, ir_write});
      end
      total++;
      if (state !== 4'd0) begin
         bad++;
         $display("FAIL post_reset_state: got %0d expected 0", state);
      end
      mem_ready = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   // R-type with two fetch wait cycles
   task automatic test_r_type();
      logic [3:0] exp_s [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
      bit         rdy   [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0110011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL r_type_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         if (i < 2) begin
            total++;
            if ({mem_req, ir_write, pc_write} !== 3'b100) begin
               bad++;
               $display("FAIL r_type_fetch_wait step%0d: got %b expected 100", i, {mem_req, ir_write, pc_write});
            end
         end
         if (exp_s[i] == 4'd6) begin
            total++;
            if ({alu_op, is_imm, alu_src_a, alu_src_b} !== 7'b10_0_10_00) begin
               bad++;
               $display("FAIL r_type_exec: got %b expected 1001000", {alu_op, is_imm, alu_src_a, alu_src_b});
            end
         end
         if (exp_s[i] == 4'd8) begin
            total++;
            if ({reg_write, result_src} !== 3'b1_00) begin
               bad++;
               $display("FAIL r_type_wb: got %b expected 100", {reg_write, result_src});
            end
         end
         #1;
         tick();
      end
      $display("test_r_type done");
   endtask

   // OP-IMM
   task automatic test_i_type();
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
      bit         rdy   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0010011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL i_type_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         if (exp_s[i] == 4'd7) begin
            total++;
            if ({alu_op, is_imm, alu_src_b} !== 5'b10_1_01) begin
               bad++;
               $display("FAIL i_type_exec: got %b expected 10101", {alu_op, is_imm, alu_src_b});
            end
         end
         #1;
         tick();
      end
      $display("test_i_type done");
   endtask

   // Load with one wait cycle in MEMREAD
   task automatic test_load();
      logic [3:0] exp_s [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
      bit         rdy   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      opcode = 7'b0000011;
      for (int i = 0; i < 7; i++) begin
         mem_ready = rdy[i];
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL load_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         if (exp_s[i] == 4'd3) begin
            total++;
            if ({mem_req, mem_write, adr_src} !== 3'b101) begin
               bad++;
               $display("FAIL load_memread step%0d: got %b expected 101", i, {mem_req, mem_write, adr_src});
            end
         end
         if (exp_s[i] == 4'd4) begin
            total++;
            if ({reg_write, result_src, mem_req} !== 4'b1_01_0) begin
               bad++;
               $display("FAIL load_memwb: got %b expected 1010", {reg_write, result_src, mem_req});
            end
         end
         #1;
         tick();
      end
      $display("test_load done");
   endtask

   // JALR: pc_write only in a completing FETCH and in JAL
   task automatic test_jalr();
      logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd11, 4'd10, 4'd8, 4'd0};
      bit         rdy   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       exp_pw;
      opcode = 7'b1100111;
      for (int i = 0; i < 6; i++) begin
         mem_ready = rdy[i];
         exp_pw    = (exp_s[i] == 4'd10) || ((exp_s[i] == 4'd0) && rdy[i]);
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL jalr_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         total++;
         if (pc_write !== exp_pw) begin
            bad++;
            $display("FAIL jalr_pc_write step%0d: got %b expected %b", i, pc_write, exp_pw);
         end
         if (exp_s[i] == 4'd11) begin
            total++;
            if ({alu_src_a, alu_src_b, alu_op} !== 6'b10_01_00) begin
               bad++;
               $display("FAIL jalr_target: got %b expected 100100", {alu_src_a, alu_src_b, alu_op});
            end
         end
         #1;
         tick();
      end
      $display("test_jalr done");
   endtask

   // Conditional branch
   task automatic test_branch();
      logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
      bit         rdy   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      opcode = 7'b1100011;
      for (int i = 0; i < 4; i++) begin
         mem_ready = rdy[i];
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL branch_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         total++;
         if (branch !== (exp_s[i] == 4'd9)) begin
            bad++;
            $display("FAIL branch_flag step%0d: got %b expected %b", i, branch, (exp_s[i] == 4'd9));
         end
         if (exp_s[i] == 4'd9) begin
            total++;
            if ({alu_op, alu_src_a, alu_src_b, pc_write} !== 7'b01_10_00_0) begin
               bad++;
               $display("FAIL branch_ctrl: got %b expected 0110000", {alu_op, alu_src_a, alu_src_b, pc_write});
            end
         end
         #1;
         tick();
      end
      $display("test_branch done");
   endtask

   // LUI, AUIPC, JAL, store issued back to back with zero-wait memory
   task automatic test_back_to_back();
      logic [6:0] ops   [4]  = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b0100011};
      logic [3:0] exp_s [16] = '{4'd0, 4'd1, 4'd12, 4'd8,
                                 4'd0, 4'd1, 4'd8,
                                 4'd0, 4'd1, 4'd10, 4'd8,
                                 4'd0, 4'd1, 4'd2, 4'd5,
                                 4'd0};
      int k = 0;
      for (int i = 0; i < 16; i++) begin
         mem_ready = (i != 15);
         if (exp_s[i] == 4'd0 && k < 4) begin
            opcode = ops[k];
            k++;
         end
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL b2b_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         if (exp_s[i] == 4'd12) begin
            total++;
            if ({alu_src_a, alu_src_b, alu_op} !== 6'b11_01_00) begin
               bad++;
               $display("FAIL b2b_lui: got %b expected 110100", {alu_src_a, alu_src_b, alu_op});
            end
         end
         if (exp_s[i] == 4'd10) begin
            total++;
            if ({pc_write, alu_src_a, alu_src_b, result_src} !== 7'b1_01_10_00) begin
               bad++;
               $display("FAIL b2b_jal: got %b expected 1011000", {pc_write, alu_src_a, alu_src_b, result_src});
            end
         end
         if (exp_s[i] == 4'd5) begin
            total++;
            if ({mem_req, mem_write, adr_src, reg_write} !== 4'b1110) begin
               bad++;
               $display("FAIL b2b_store: got %b expected 1110", {mem_req, mem_write, adr_src, reg_write});
            end
         end
         #1;
         tick();
      end
      $display("test_back_to_back done");
   endtask

   // Unrecognised opcode
   task automatic test_illegal();
`ifdef CTRL_TRAP_EN
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd13, 4'd13, 4'd13};
      bit         exp_il[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         n = 5;
`else
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
      bit         exp_il[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      int         n = 3;
`endif
      opcode = 7'b1111111;
      for (int i = 0; i < n; i++) begin
         mem_ready = (i < 2) || (n == 5);
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL illegal_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         total++;
         if (illegal_instr !== exp_il[i]) begin
            bad++;
            $display("FAIL illegal_flag step%0d: got %b expected %b", i, illegal_instr, exp_il[i]);
         end
         if (exp_il[i]) begin
            total++;
            if ({mem_req, pc_write, ir_write, reg_write} !== 4'b0000) begin
               bad++;
               $display("FAIL trap_outputs step%0d: got %b expected 0000", i, {mem_req, pc_write, ir_write, reg_write});
            end
         end
         #1;
         tick();
      end
      // Reset is the only way out of TRAP
      reset     = 1'b1;
      mem_ready = 1'b0;
      #1;
      total++;
      if ({state, illegal_instr} !== 5'b0000_0) begin
         bad++;
         $display("FAIL illegal_reset: got %b expected 00000", {state, illegal_instr});
      end
      tick();
      reset = 1'b0;
      #1;
      total++;
      if (state !== 4'd0) begin
         bad++;
         $display("FAIL illegal_recover: got %0d expected 0", state);
      end
      tick();
      $display("test_illegal done");
   endtask

   // Reset during a MEMWRITE wait abandons the request immediately
   task automatic test_reset_in_memwrite();
      logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
      bit         rdy   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      opcode = 7'b0100011;
      for (int i = 0; i < 5; i++) begin
         mem_ready = rdy[i];
         #1;
         total++;
         if (state !== exp_s[i]) begin
            bad++;
            $display("FAIL mw_state step%0d: got %0d expected %0d", i, state, exp_s[i]);
         end
         if (exp_s[i] == 4'd5) begin
            total++;
            if ({mem_req, mem_write} !== 2'b11) begin
               bad++;
               $display("FAIL mw_wait step%0d: got %b expected 11", i, {mem_req, mem_write});
            end
         end
         #1;
         if (i < 4) tick();
      end
      reset = 1'b1;
      #1;
      total++;
      if ({mem_req, mem_write, adr_src} !== 3'b000) begin
         bad++;
         $display("FAIL mw_reset_abort: got %b expected 000", {mem_req, mem_write, adr_src});
      end
      total++;
      if (state !== 4'd0) begin
         bad++;
         $display("FAIL mw_reset_state: got %0d expected 0", state);
      end
      tick();
      reset = 1'b0;
      #1;
      total++;
      if ({state, mem_req} !== 5'b0000_1) begin
         bad++;
         $display("FAIL mw_after_reset: got %b expected 00001", {state, mem_req});
      end
      $display("test_reset_in_memwrite done");
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 7'b0000000;
      @(negedge clk);
      @(posedge clk);
      #1;
      test_reset();
      test_r_type();
      test_i_type();
      test_load();
      test_jalr();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_reset_in_memwrite();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
